// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encoding and small helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DATA_W            - serial byte width shared by arbiter, transmitter and receiver
//   SEND_PULSE_DEF    - default number of cycles the active-low send strobe is held
//   FRAME_CYCLES_DEF  - default number of cycles reserved for one serial frame
//   state_e           - arbiter FSM state encoding
//   max_int           - helper used to size shared down-counters
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int SEND_PULSE_DEF   = 2;
    localparam int FRAME_CYCLES_DEF = 110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first set request after the last winner, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req_i     - per-requester valid bits
//   last_i    - index of the most recent winner (lowest priority this pick)
//   any_o     - at least one request is set
//   winner_o  - index of the chosen requester (0 when any_o is low)
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               any_o,
    output logic [ID_W-1:0]    winner_o
);

    // Index that is k positions after base, modulo NUM_REQ. base < NUM_REQ and
    // k <= NUM_REQ, so a single conditional subtract is enough for any NUM_REQ.
    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    // Walk the rotation from the farthest position back to the nearest one so
    // the last assignment made is the highest-priority set request. This keeps
    // the loop free of early exits and gives a plain priority mux.
    always_comb begin
        logic [ID_W-1:0] idx;
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = rot_idx(last_i, k);
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_transmitter between NUM_REQ byte producers.
// Latency: grant, ack and tx_send low on the first IDLE edge with a request.
// Backpressure: requests are held until ack; none granted while a frame runs.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   req          - per-requester valid, held until the matching ack
//   req_data     - requester i's byte at [i*DATA_W +: DATA_W]
//   ack          - one-cycle pulse: byte from requester i accepted
//   tx_data      - byte to the transmitter, stable until the next grant
//   tx_send      - active-low send strobe, idles high
//   busy         - high while a frame is in progress (PULSE or WAIT)
//   grant_id     - index of the last granted requester
//   frame_count  - number of frames launched, wraps silently
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = uart_pkg::DATA_W,
    parameter int SEND_PULSE   = SEND_PULSE_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int CNT_W        = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_send,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [CNT_W-1:0]          frame_count
);

    // One down-counter serves both the pulse and the frame wait, so it is
    // sized for whichever reload value is larger.
    localparam int CYC_MAX = max_int(SEND_PULSE, FRAME_CYCLES);
    localparam int CW      = $clog2(CYC_MAX + 1);

    localparam logic [CW-1:0] PULSE_RELOAD = CW'(SEND_PULSE - 1);
    localparam logic [CW-1:0] FRAME_RELOAD = CW'(FRAME_CYCLES - 1);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [DATA_W-1:0]     tx_data_q;
    logic                  tx_send_q;
    logic                  busy_q;
    logic [ID_W-1:0]       grant_id_q;
    logic [ID_W-1:0]       last_q;
    logic [CNT_W-1:0]      frame_count_q;

    logic [CNT_W-1:0]      frame_count_d;
    logic                  pick_any;
    logic [ID_W-1:0]       pick_idx;
    logic [DATA_W-1:0]     pick_data;
    logic [NUM_REQ-1:0]    pick_onehot;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    // Byte lane of the winner; an explicit compare loop avoids a variable
    // part-select whose index width would depend on NUM_REQ.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_idx) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign pick_onehot   = NUM_REQ'(1) << pick_idx;
    assign frame_count_d = frame_count_q + CNT_W'(1);

    // Single FSM block; every output is a register so the transmitter sees
    // glitch-free strobes. The reset branch forces tx_send high immediately,
    // which abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ack_q         <= '0;
            tx_data_q     <= '0;
            tx_send_q     <= 1'b1;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            frame_count_q <= '0;
        end else begin
            // ack is a single-cycle pulse unless a grant re-asserts it below.
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    tx_send_q <= 1'b1;
                    if (pick_any) begin
                        ack_q         <= pick_onehot;
                        tx_data_q     <= pick_data;
                        tx_send_q     <= 1'b0;
                        grant_id_q    <= pick_idx;
                        last_q        <= pick_idx;
                        frame_count_q <= frame_count_d;
                        busy_q        <= 1'b1;
                        cnt_q         <= PULSE_RELOAD;
                        state_q       <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        tx_send_q <= 1'b1;
                        cnt_q     <= FRAME_RELOAD;
                        state_q   <= WAIT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT: begin
                    // Requests are deliberately not sampled here: the first
                    // grant after a frame happens on the edge after busy falls.
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    tx_send_q <= 1'b1;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, SEND_PULSE=2, FRAME_CYCLES=110).
// A timeline model tracks when the last grant happened and derives every output from
// the elapsed time since then; directed tables and sequences cover the corner cases.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int SP = 2;
    localparam int FC = 110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] frame_count;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (8),
        .SEND_PULSE   (SP),
        .FRAME_CYCLES (FC),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the arbiter is characterised only by when the last grant
    // happened, who won, which byte, and how many frames were launched.
    int          cyc    = 0;
    int          m_gt   = -1000;
    int          m_last = N - 1;
    int          m_id   = 0;
    int          m_fc   = 0;
    logic [7:0]  m_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gt   = -1000;
        m_last = N - 1;
        m_id   = 0;
        m_fc   = 0;
        m_data = 8'h00;
    endtask

    // A grant is possible only once a full pulse+frame has elapsed and one
    // further idle edge has passed since the previous grant.
    task automatic model_step();
        int idx;
        cyc++;
        if ((cyc - m_gt) >= (SP + FC + 1) && req != 4'b0000) begin
            idx = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (req[idx]) break;
            end
            m_gt   = cyc;
            m_id   = idx;
            m_last = idx;
            m_data = req_data[idx*8 +: 8];
            m_fc   = (m_fc + 1) % 65536;
        end
    endtask

    task automatic check_all();
        int d;
        logic [3:0] e_ack;
        d     = cyc - m_gt;
        e_ack = (d == 0) ? (4'b0001 << m_id) : 4'b0000;
        chk("ack", ack, e_ack);
        chk("tx_send", tx_send, (d >= 0 && d < SP) ? 1'b0 : 1'b1);
        chk("busy", busy, (d >= 0 && d < SP + FC) ? 1'b1 : 1'b0);
        chk("tx_data", tx_data, m_data);
        chk("grant_id", grant_id, m_id);
        chk("frame_count", frame_count, m_fc);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs are
    // compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        if (rst_n) check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        chk("rst_tx_send", tx_send, 1'b1);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_frame_count", frame_count, 16'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        if (busy) chk("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_ack(input int bound, output logic [3:0] a);
        int k;
        k = 0;
        a = 4'b0000;
        while (a == 4'b0000 && k < bound) begin
            tick();
            a = ack;
            k++;
        end
        if (a == 4'b0000) chk("wait_ack_timeout", a != 4'b0000, 1'b1);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] a;
        int         t_prev;
        int         busy_cyc;
        int         low_cyc;
        logic       saw_ack1;
        int         n_grants;
        int         r;
        int         exp_fair[4];

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;

        // Each vector starts from IDLE; the winner follows from the pointer
        // left by the previous vector (pointer starts at 3 after reset).
        vecs[0] = '{4'b0010, 32'h0000_C100, 4'b0010, 2'd1, 8'hC1};
        vecs[1] = '{4'b1111, 32'h4433_2211, 4'b0100, 2'd2, 8'h33};
        vecs[2] = '{4'b0011, 32'h0000_5AA5, 4'b0001, 2'd0, 8'hA5};
        vecs[3] = '{4'b1000, 32'h7E00_0000, 4'b1000, 2'd3, 8'h7E};
        vecs[4] = '{4'b1001, 32'h8100_0018, 4'b0001, 2'd0, 8'h18};
        vecs[5] = '{4'b0110, 32'h00F0_0F00, 4'b0010, 2'd1, 8'h0F};
        vecs[6] = '{4'b1100, 32'h9CC9_0000, 4'b0100, 2'd2, 8'hC9};
        vecs[7] = '{4'b1011, 32'hDE00_BEEF, 4'b1000, 2'd3, 8'hDE};

        // Reset values, then the directed table.
        do_reset(3);
        for (int v = 0; v < 8; v++) begin
            req      = vecs[v].req;
            req_data = vecs[v].data;
            tick();
            chk("tbl_ack", ack, vecs[v].exp_ack);
            chk("tbl_grant_id", grant_id, vecs[v].exp_id);
            chk("tbl_tx_data", tx_data, vecs[v].exp_byte);
            chk("tbl_frame_count", frame_count, 16'(v + 1));
            req      = 4'b0000;
            busy_cyc = 1;
            low_cyc  = tx_send ? 0 : 1;
            for (int k = 0; k < 200 && busy; k++) begin
                tick();
                if (busy) busy_cyc++;
                if (!tx_send) low_cyc++;
            end
            chk("tbl_busy_cycles", busy_cyc, SP + FC);
            chk("tbl_send_low_cycles", low_cyc, SP);
            chk("tbl_tx_data_hold", tx_data, vecs[v].exp_byte);
        end

        // All four request at once and each drops on its ack.
        do_reset(2);
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        t_prev   = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(300, a);
            chk("simul_ack", a, 4'b0001 << g);
            chk("simul_grant_id", grant_id, g);
            chk("simul_tx_data", tx_data, 8'((g + 1) * 17));
            if (g > 0) chk("simul_spacing", cyc - t_prev, SP + FC + 1);
            t_prev = cyc;
            req    = req & ~a;
        end
        wait_idle(200);
        chk("simul_frame_count", frame_count, 16'd4);

        // Two requesters held continuously alternate.
        do_reset(2);
        req         = 4'b0101;
        req_data    = 32'h0055_00AA;
        exp_fair[0] = 0;
        exp_fair[1] = 2;
        exp_fair[2] = 0;
        exp_fair[3] = 2;
        for (int g = 0; g < 4; g++) begin
            wait_ack(300, a);
            chk("fair_grant_id", grant_id, exp_fair[g]);
        end
        req = 4'b0000;
        wait_idle(200);

        // Request raised and withdrawn while busy is never granted.
        req = 4'b0001;
        tick();
        chk("withdraw_first_ack", ack, 4'b0001);
        req = 4'b0000;
        repeat (10) tick();
        req[1] = 1'b1;
        saw_ack1 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ack[1]) saw_ack1 = 1'b1;
        end
        req[1] = 1'b0;
        for (int k = 0; k < 200 && busy; k++) begin
            tick();
            if (ack[1]) saw_ack1 = 1'b1;
        end
        repeat (5) begin
            tick();
            if (ack[1]) saw_ack1 = 1'b1;
        end
        chk("withdraw_no_ack", saw_ack1, 1'b0);
        chk("withdraw_frame_count", frame_count, 16'd5);

        // Reset in the middle of WAIT with requester 3 pending.
        do_reset(2);
        req      = 4'b0001;
        req_data = 32'hB700_0005;
        tick();
        req = 4'b1000;
        repeat (52) tick();
        chk("midrst_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_tx_send_async", tx_send, 1'b1);
        chk("midrst_busy_async", busy, 1'b0);
        chk("midrst_frame_count", frame_count, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_ack", ack, 4'b1000);
        chk("midrst_grant_id", grant_id, 2'd3);
        chk("midrst_frame_count_after", frame_count, 16'd1);
        chk("midrst_tx_data", tx_data, 8'hB7);
        req = 4'b0000;
        wait_idle(200);

        // Random traffic against the timeline model.
        do_reset(2);
        n_grants = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (ack != 4'b0000) n_grants++;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req_data[i*8 +: 8] = 8'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (req[i]) begin
                    r = int'($urandom_range(99, 0));
                    if (r < 3) req[i] = 1'b0;
                    else if (r < 10) req_data[i*8 +: 8] = 8'($urandom);
                end else begin
                    r = int'($urandom_range(99, 0));
                    if (r < 8) begin
                        req[i]             = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end else if (r < 40) begin
                        req_data[i*8 +: 8] = 8'($urandom);
                    end
                end
            end
        end
        chk("rand_grants_seen", n_grants > 10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between NUM_REQ byte producers using round-robin arbitration.
- Each grant latches the requester's byte onto the transmitter's data input.
- It then issues the transmitter's active-low send pulse.
- It holds off the next grant for one full frame time.
- Sits directly in front of uart_transmitter. Its tx_data/tx_send outputs wire to the transmitter's data/send inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter data width.
- SEND_PULSE, 2, cycles tx_send is held low per frame (≥1).
- FRAME_CYCLES, 110, cycles reserved after the pulse for the serial frame to finish (≥1).
- CNT_W, 16, width of the frame_count statistic.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester valid; held until the matching ack.
- req_data  in  NUM_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse: byte from requester i accepted.
- tx_data  out  DATA_W  byte to the transmitter; stable for the whole frame.
- tx_send  out  1  active-low send strobe to the transmitter; idles high.
- busy  out  1  high while a frame is in progress (PULSE or WAIT).
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- frame_count  out  CNT_W  number of frames launched; wraps at 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; tx_send=1 immediately; tx_data=0; ack=0; busy=0; grant_id=0; frame_count=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, PULSE, WAIT.
- IDLE, at an edge with |req: select winner w as the first set req in order last+1, last+2, …, last (mod NUM_REQ). On that edge:
  - ack[w]<=1; tx_data<=req_data[w]; tx_send<=0; grant_id<=w; last<=w;
  - frame_count<=frame_count+1; busy<=1; cnt<=SEND_PULSE-1; state<=PULSE.
- IDLE with req=0: hold; tx_send=1; ack=0.
- PULSE:
  - ack returns to 0 after one cycle; tx_send stays 0.
  - When cnt==0: tx_send<=1, cnt<=FRAME_CYCLES-1, state<=WAIT. Otherwise cnt decrements.
  - tx_send is therefore low for exactly SEND_PULSE cycles.
- WAIT:
  - tx_send=1, busy=1.
  - When cnt==0: busy<=0, state<=IDLE. Otherwise cnt decrements.
- Timing:
  - busy is high for SEND_PULSE+FRAME_CYCLES cycles.
  - Minimum grant-to-grant spacing is SEND_PULSE+FRAME_CYCLES+1 cycles; no grant is issued in the cycle busy falls.
- req is ignored outside IDLE. A requester may change req_data or drop req at any time before its ack; a dropped req is never granted.
- After ack, the requester drops req or presents its next byte. Because state has already left IDLE, no double grant is possible.
- tx_data changes only on a grant edge; it holds its value after the frame until the next grant.
- rst_n low mid-PULSE or mid-WAIT: the frame is abandoned and tx_send goes high asynchronously. Pending reqs are re-arbitrated from requester 0 after release.
- frame_count wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W=8;
  - the state encoding (IDLE=2'd0, PULSE=2'd1, WAIT=2'd2);
  - default SEND_PULSE and FRAME_CYCLES, shared with uart_transmitter and uart_receiver so bit timing stays consistent.
- One sub-module is natural: uart_rr_pick.
  - Purely combinational rotate/priority-encode/unrotate.
  - Inputs: req, last. Outputs: any, winner index.
- The FSM, counter and output registers stay in uart_tx_arbiter.

Test Plan:
All scenarios use NUM_REQ=4, SEND_PULSE=2, FRAME_CYCLES=110, clk period 10 ns.
1. Reset: hold rst_n=0 for 3 cycles → tx_send=1, tx_data=0x00, ack=0, busy=0, grant_id=0, frame_count=0.
2. Single request: req=4'b0010 with byte 0xC1 → ack=4'b0010 for exactly 1 cycle; tx_data=0xC1; tx_send low 2 cycles; busy high 112 cycles; frame_count=1. The looped-back uart_receiver reports data=0xC1, err=0.
3. Simultaneous requests: req=4'b1111 with bytes 0x11/0x22/0x33/0x44, each dropped on its ack → grant order 0,1,2,3; acks spaced 113 cycles apart; tx_data sequence 0x11,0x22,0x33,0x44; frame_count=4.
4. Fairness: req[0] and req[2] held high continuously → grant_id alternates 0,2,0,2; neither requester is granted twice in a row.
5. Reset mid-frame: rst_n low 50 cycles into WAIT with req[3] pending → tx_send=1 asynchronously, busy=0. After release, requester 3 is granted on the first IDLE edge with frame_count=1.
6. Withdrawn request: req[1] raised and then dropped while busy, before any grant → ack[1] never pulses; frame_count unchanged.
